// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair: FSM states and the idle fill word.
`timescale 1ns/1ps
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic [7:0] FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_if.sv
// Four-wire SPI bus plus the responder's MISO output enable.
`timescale 1ns/1ps
interface spi_if;

  logic sck;
  logic csx;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sck, csx, mosi, input  miso, miso_oe);
  modport slave  (input  sck, csx, mosi, output miso, miso_oe);

endinterface

// File: rtl/spi_edge_sync.sv
// Three-flop synchronizer for an asynchronous level with rise/fall strobes in the clk domain.
`timescale 1ns/1ps
module spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RESET_VAL}};
    else        sync_q <= {sync_q[1:0], async_i};
  end

  assign sync_o = sync_q[1];
  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples SCK/CSX/MOSI, shifts MSB first, one-word transmit buffer.
`timescale 1ns/1ps
module spi_slave
  import spi_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] FILL  = WIDTH'(FILL_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_if.slave             bus,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             rx_abort_o,
  output logic             tx_underrun_o
);

  localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic sck_s, cs_s;
  logic mosi_s1_q, mosi_s_q;

  spi_edge_sync #(.RESET_VAL(1'b0)) u_sck_sync (
    .clk, .rst_n, .async_i(bus.sck), .sync_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_edge_sync #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk, .rst_n, .async_i(bus.csx), .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_s1_q <= 1'b0;
      mosi_s_q  <= 1'b0;
    end else begin
      mosi_s1_q <= bus.mosi;
      mosi_s_q  <= mosi_s1_q;
    end
  end

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic             tx_pending_q, tx_pending_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_abort_q, rx_abort_d;
  logic             tx_underrun_q, tx_underrun_d;
  logic             load_tx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    tx_buf_d      = tx_buf_q;
    tx_pending_d  = tx_pending_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_abort_d    = 1'b0;
    tx_underrun_d = 1'b0;
    load_tx       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load_tx   = 1'b1;
        end
      end
      ACTIVE: begin
        // CSX release takes priority over a coincident SCK edge.
        if (cs_rise) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_abort_d = (bit_cnt_q != '0);
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s_q};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d  = {rx_shift_q[WIDTH-2:0], mosi_s_q};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q == '0) load_tx = 1'b1;
          else                 tx_shift_d = tx_shift_q << 1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_tx) begin
      if (tx_pending_q) begin
        tx_shift_d   = tx_buf_q;
        tx_pending_d = 1'b0;
      end else begin
        tx_shift_d    = FILL;
        tx_underrun_d = 1'b1;
      end
    end

    // A word written at a load point is not bypassed; it waits for the next word boundary.
    if (tx_valid_i && !tx_pending_q) begin
      tx_buf_d     = tx_data_i;
      tx_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      tx_buf_q      <= '0;
      tx_pending_q  <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_abort_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_buf_q      <= tx_buf_d;
      tx_pending_q  <= tx_pending_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_abort_q    <= rx_abort_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign bus.miso      = (state_q == ACTIVE) ? tx_shift_q[WIDTH-1] : 1'b0;
  assign bus.miso_oe   = (state_q == ACTIVE);
  assign tx_ready_o    = ~tx_pending_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_abort_o    = rx_abort_q;
  assign tx_underrun_o = tx_underrun_q;

  logic unused_sync;
  assign unused_sync = sck_s ^ cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master plus pulse counters on the local side.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam int W    = 8;
  localparam int HALF = 60;  // SCK half period: 6 clk periods

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid, rx_abort, tx_underrun;

  spi_if bus();

  spi_slave #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus.slave),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_abort_o    (rx_abort),
    .tx_underrun_o (tx_underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rxv_cnt = 0, abort_cnt = 0, und_cnt = 0;
  logic [W-1:0] rx_log[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt++;
      rx_log.push_back(rx_data);
    end
    if (rx_abort)    abort_cnt++;
    if (tx_underrun) und_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] log_at(input int idx);
    if (idx < rx_log.size()) return rx_log[idx];
    return 'x;
  endfunction

  task automatic write_tx(input logic [W-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    bus.csx = 1'b0;
    #(HALF + 20);
  endtask

  task automatic cs_high();
    #HALF;
    bus.csx = 1'b1;
    #(2 * HALF);
  endtask

  task automatic shift_bits(input logic [W-1:0] d, input int n, output logic [W-1:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = d[W-1-i];
      #HALF;
      rd = {rd[W-2:0], bus.miso};
      bus.sck = 1'b1;
      #HALF;
      bus.sck = 1'b0;
    end
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rd, rd2;
    int rxv0, abt0, und0, lg0;

    bus.sck = 1'b0; bus.csx = 1'b1; bus.mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", bus.miso, 0);
    check("rst_miso_oe", bus.miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_pulses", {rx_abort, tx_underrun}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: pending A5 is returned while 3C is received
    write_tx(8'hA5);
    check("t1_ready_low", tx_ready, 0);
    rxv0 = rxv_cnt;
    cs_low();
    check("t1_miso_oe", bus.miso_oe, 1);
    check("t1_ready_back", tx_ready, 1);
    shift_bits(8'h3C, 8, rd);
    cs_high();
    check("t1_miso", rd, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    check("t1_rx_valid_cnt", rxv_cnt - rxv0, 1);
    check("t1_miso_oe_off", bus.miso_oe, 0);

    // 2: nothing pending, FILL is sent and underrun flagged at CSX fall
    und0 = und_cnt;
    cs_low();
    check("t2_underrun_at_cs", und_cnt - und0, 1);
    shift_bits(8'h00, 8, rd);
    cs_high();
    check("t2_miso_fill", rd, 8'hFF);
    check("t2_rx_data", rx_data, 8'h00);

    // 3: two words back to back, second tx word written mid-frame
    write_tx(8'h12);
    rxv0 = rxv_cnt;
    lg0  = rx_log.size();
    cs_low();
    check("t3_ready_after_load", tx_ready, 1);
    write_tx(8'h34);
    shift_bits(8'hC1, 8, rd);
    shift_bits(8'hC2, 8, rd2);
    cs_high();
    check("t3_miso_w0", rd, 8'h12);
    check("t3_miso_w1", rd2, 8'h34);
    check("t3_rx_valid_cnt", rxv_cnt - rxv0, 2);
    check("t3_rx_w0", log_at(lg0), 8'hC1);
    check("t3_rx_w1", log_at(lg0 + 1), 8'hC2);

    // 4: partial word aborted, then a clean word
    rxv0 = rxv_cnt;
    abt0 = abort_cnt;
    cs_low();
    shift_bits(8'hFF, 5, rd);
    cs_high();
    check("t4_abort_cnt", abort_cnt - abt0, 1);
    check("t4_no_rx_valid", rxv_cnt - rxv0, 0);
    check("t4_rx_data_held", rx_data, 8'hC2);
    cs_low();
    shift_bits(8'h5A, 8, rd);
    cs_high();
    check("t4_rx_data_next", rx_data, 8'h5A);

    // 5: reset in the middle of a frame
    write_tx(8'h81);
    rxv0 = rxv_cnt;
    cs_low();
    shift_bits(8'hE7, 3, rd);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_miso_oe", bus.miso_oe, 0);
    check("t5_rst_miso", bus.miso, 0);
    check("t5_rst_tx_ready", tx_ready, 1);
    check("t5_rst_rx_data", rx_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    shift_bits(8'hE7, 5, rd);
    cs_high();
    check("t5_no_rx_valid", rxv_cnt - rxv0, 0);
    cs_low();
    shift_bits(8'h99, 8, rd);
    cs_high();
    check("t5_rx_after", rx_data, 8'h99);
    check("t5_fill_after", rd, 8'hFF);

    // 6: a second write while one is pending is ignored
    write_tx(8'h66);
    @(negedge clk);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t6_ready_low", tx_ready, 0);
    cs_low();
    shift_bits(8'h0F, 8, rd);
    cs_high();
    check("t6_miso_first", rd, 8'h66);
    cs_low();
    shift_bits(8'hF0, 8, rd);
    cs_high();
    check("t6_77_dropped", rd, 8'hFF);
    check("t6_rx_data", rx_data, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
